// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 16-bit pipelined CPU, between EX and write-back.
// Non-memory instructions pass straight into the MEM/WB register with one
// cycle of latency. Loads and stores are captured into holding registers and
// issued to the data memory over a req/rdy handshake. Upstream stalls until
// the memory completes. A halt instruction parks the stage until reset.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_vld                EX presents a valid instruction
//   ex_dst                ALU result / memory word address (low ADDR_W bits)
//   ex_zr                 ALU zero flag
//   ex_st_data            store data
//   ex_mem_re, ex_mem_we  load / store request (both set = store)
//   ex_rf_we, ex_rf_dst   register-file write enable and destination
//   ex_hlt                halt instruction
//   stall                 upstream must hold its outputs
//   dm_req, dm_we         memory request, 1 = write
//   dm_addr, dm_wdata     memory word address and write data
//   dm_rdata, dm_rdy      memory read data and completion strobe
//   wb_vld, wb_we, wb_zr, wb_hlt, wb_data, wb_dst   MEM/WB register contents
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_vld,
  input  logic [DATA_W-1:0] ex_dst,
  input  logic              ex_zr,
  input  logic [DATA_W-1:0] ex_st_data,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic              ex_rf_we,
  input  logic [REG_W-1:0]  ex_rf_dst,
  input  logic              ex_hlt,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_rdy,
  output logic              wb_vld,
  output logic              wb_we,
  output logic              wb_zr,
  output logic              wb_hlt,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_dst
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Holding registers for the in-flight memory operation.
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic              is_st_q,  is_st_d;
  logic              rf_we_q,  rf_we_d;
  logic [REG_W-1:0]  rf_dst_q, rf_dst_d;
  logic              zr_q,     zr_d;

  // MEM/WB pipeline register.
  logic              wb_vld_q,  wb_vld_d;
  logic              wb_we_q,   wb_we_d;
  logic              wb_zr_q,   wb_zr_d;
  logic              wb_hlt_q,  wb_hlt_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_dst_q,  wb_dst_d;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_st_d   = is_st_q;
    rf_we_d   = rf_we_q;
    rf_dst_d  = rf_dst_q;
    zr_d      = zr_q;
    // wb_vld/wb_we are single-cycle qualifiers; the payload holds.
    wb_vld_d  = 1'b0;
    wb_we_d   = 1'b0;
    wb_zr_d   = wb_zr_q;
    wb_hlt_d  = wb_hlt_q;
    wb_data_d = wb_data_q;
    wb_dst_d  = wb_dst_q;

    unique case (state_q)
      IDLE: begin
        if (ex_vld) begin
          if (ex_hlt) begin
            // Halt wins over any memory op carried by the same instruction.
            wb_vld_d = 1'b1;
            wb_hlt_d = 1'b1;
            state_d  = HALTED;
          end else if (ex_mem_re || ex_mem_we) begin
            addr_d   = ex_dst[ADDR_W-1:0];
            wdata_d  = ex_st_data;
            is_st_d  = ex_mem_we;  // re and we together resolve to a store
            rf_we_d  = ex_rf_we;
            rf_dst_d = ex_rf_dst;
            zr_d     = ex_zr;
            state_d  = BUSY;
          end else begin
            wb_vld_d  = 1'b1;
            wb_we_d   = ex_rf_we;
            wb_data_d = ex_dst;
            wb_dst_d  = ex_rf_dst;
            wb_zr_d   = ex_zr;
          end
        end
      end

      BUSY: begin
        if (dm_rdy) begin
          wb_vld_d  = 1'b1;
          wb_dst_d  = rf_dst_q;
          wb_zr_d   = zr_q;
          wb_data_d = is_st_q ? wdata_q : dm_rdata;
          wb_we_d   = rf_we_q && !is_st_q;
          state_d   = IDLE;
        end
      end

      HALTED: begin
        // Parked until reset; ex_vld and dm_rdy are ignored.
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_st_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_dst_q  <= '0;
      zr_q      <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_zr_q   <= 1'b0;
      wb_hlt_q  <= 1'b0;
      wb_data_q <= '0;
      wb_dst_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_st_q   <= is_st_d;
      rf_we_q   <= rf_we_d;
      rf_dst_q  <= rf_dst_d;
      zr_q      <= zr_d;
      wb_vld_q  <= wb_vld_d;
      wb_we_q   <= wb_we_d;
      wb_zr_q   <= wb_zr_d;
      wb_hlt_q  <= wb_hlt_d;
      wb_data_q <= wb_data_d;
      wb_dst_q  <= wb_dst_d;
    end
  end

  // Handshake outputs decode registered state only: no path from ex_* to dm_*.
  assign stall    = (state_q != IDLE);
  assign dm_req   = (state_q == BUSY);
  assign dm_we    = dm_req && is_st_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;

  assign wb_vld  = wb_vld_q;
  assign wb_we   = wb_we_q;
  assign wb_zr   = wb_zr_q;
  assign wb_hlt  = wb_hlt_q;
  assign wb_data = wb_data_q;
  assign wb_dst  = wb_dst_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: ALU pass-through, multi-cycle load followed by
// an ALU op, zero-wait store, idle dm_rdy, reset in the middle of a memory op,
// and halt. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_vld;
  logic [15:0] ex_dst;
  logic        ex_zr;
  logic [15:0] ex_st_data;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic        ex_rf_we;
  logic [3:0]  ex_rf_dst;
  logic        ex_hlt;
  logic        stall;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_rdy;
  logic        wb_vld;
  logic        wb_we;
  logic        wb_zr;
  logic        wb_hlt;
  logic [15:0] wb_data;
  logic [3:0]  wb_dst;

  int checks   = 0;
  int failures = 0;

  mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_vld     (ex_vld),
    .ex_dst     (ex_dst),
    .ex_zr      (ex_zr),
    .ex_st_data (ex_st_data),
    .ex_mem_re  (ex_mem_re),
    .ex_mem_we  (ex_mem_we),
    .ex_rf_we   (ex_rf_we),
    .ex_rf_dst  (ex_rf_dst),
    .ex_hlt     (ex_hlt),
    .stall      (stall),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_rdy     (dm_rdy),
    .wb_vld     (wb_vld),
    .wb_we      (wb_we),
    .wb_zr      (wb_zr),
    .wb_hlt     (wb_hlt),
    .wb_data    (wb_data),
    .wb_dst     (wb_dst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; outputs are stable there and
  // inputs driven here are seen at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_vld = 0; ex_dst = '0; ex_zr = 0; ex_st_data = '0; ex_mem_re = 0;
    ex_mem_we = 0; ex_rf_we = 0; ex_rf_dst = '0; ex_hlt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    dm_rdata = '0;
    dm_rdy   = 1'b0;

    // ---------------- reset state ----------------
    #3;
    check("rst_stall",   stall,   0);
    check("rst_dm_req",  dm_req,  0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_wb_vld",  wb_vld,  0);
    check("rst_wb_hlt",  wb_hlt,  0);
    check("rst_wb_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- ALU pass-through ----------------
    ex_vld = 1; ex_dst = 16'h1234; ex_rf_we = 1; ex_rf_dst = 4'd3; ex_zr = 0;
    tick();
    check("alu_wb_vld",  wb_vld,  1);
    check("alu_wb_data", wb_data, 16'h1234);
    check("alu_wb_dst",  wb_dst,  3);
    check("alu_wb_we",   wb_we,   1);
    check("alu_stall",   stall,   0);
    check("alu_dm_req",  dm_req,  0);
    idle_inputs();
    tick();
    check("bubble_wb_vld",  wb_vld,  0);
    check("bubble_wb_we",   wb_we,   0);
    check("bubble_wb_data", wb_data, 16'h1234);
    check("bubble_wb_dst",  wb_dst,  3);

    // ---------------- load, 3 BUSY cycles, then ALU op ----------------
    ex_vld = 1; ex_mem_re = 1; ex_dst = 16'h0040; ex_rf_we = 1; ex_rf_dst = 4'd5; ex_zr = 1;
    tick();
    // Upstream now holds the next instruction: ALU op 0x0007 -> r2.
    ex_mem_re = 0; ex_dst = 16'h0007; ex_rf_dst = 4'd2; ex_zr = 0; ex_rf_we = 1;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("ld_busy%0d_dm_req", c),  dm_req,  1);
      check($sformatf("ld_busy%0d_dm_we", c),   dm_we,   0);
      check($sformatf("ld_busy%0d_dm_addr", c), dm_addr, 16'h0040);
      check($sformatf("ld_busy%0d_stall", c),   stall,   1);
      check($sformatf("ld_busy%0d_wb_vld", c),  wb_vld,  0);
      if (c == 3) begin
        dm_rdy = 1; dm_rdata = 16'hBEEF;
      end
      tick();
    end
    dm_rdy = 0; dm_rdata = 16'h0000;
    check("ld_wb_vld",  wb_vld,  1);
    check("ld_wb_data", wb_data, 16'hBEEF);
    check("ld_wb_we",   wb_we,   1);
    check("ld_wb_dst",  wb_dst,  5);
    check("ld_wb_zr",   wb_zr,   1);
    check("ld_stall",   stall,   0);
    check("ld_dm_req",  dm_req,  0);
    tick();
    idle_inputs();
    check("ld_alu_wb_vld",  wb_vld,  1);
    check("ld_alu_wb_data", wb_data, 16'h0007);
    check("ld_alu_wb_dst",  wb_dst,  2);
    check("ld_alu_wb_zr",   wb_zr,   0);
    tick();
    check("ld_alu_no_dup", wb_vld, 0);

    // ---------------- zero-wait store (re and we both set) ----------------
    dm_rdy = 1;
    ex_vld = 1; ex_mem_we = 1; ex_mem_re = 1; ex_dst = 16'h00FF;
    ex_st_data = 16'hA5A5; ex_rf_we = 1; ex_rf_dst = 4'd7;
    tick();
    idle_inputs();
    check("st_dm_req",   dm_req,   1);
    check("st_dm_we",    dm_we,    1);
    check("st_dm_addr",  dm_addr,  16'h00FF);
    check("st_dm_wdata", dm_wdata, 16'hA5A5);
    check("st_stall",    stall,    1);
    tick();
    check("st_wb_vld",  wb_vld,  1);
    check("st_wb_we",   wb_we,   0);
    check("st_wb_data", wb_data, 16'hA5A5);
    check("st_dm_req_drop", dm_req, 0);
    // dm_rdy still high while idle: must not produce anything.
    tick();
    check("idle_rdy_wb_vld", wb_vld, 0);
    check("idle_rdy_dm_req", dm_req, 0);
    dm_rdy = 0;

    // ---------------- reset during BUSY ----------------
    ex_vld = 1; ex_mem_re = 1; ex_dst = 16'h0123; ex_rf_we = 1; ex_rf_dst = 4'd9;
    tick();
    idle_inputs();
    check("rb_dm_req", dm_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_dm_req_low", dm_req,  0);
    check("rb_stall_low",  stall,   0);
    check("rb_dm_addr",    dm_addr, 0);
    check("rb_wb_data",    wb_data, 0);
    check("rb_wb_dst",     wb_dst,  0);
    #2 rst_n = 1'b1;
    tick();
    ex_vld = 1; ex_mem_we = 1; ex_dst = 16'h0010; ex_st_data = 16'h5A5A;
    tick();
    idle_inputs();
    check("rb_st_dm_req",   dm_req,   1);
    check("rb_st_dm_wdata", dm_wdata, 16'h5A5A);
    dm_rdy = 1;
    tick();
    dm_rdy = 0;
    check("rb_st_wb_vld",  wb_vld,  1);
    check("rb_st_wb_data", wb_data, 16'h5A5A);
    check("rb_st_wb_we",   wb_we,   0);

    // ---------------- halt (with a memory op on the same instruction) -----
    tick();
    ex_vld = 1; ex_hlt = 1; ex_mem_re = 1; ex_dst = 16'h0200;
    tick();
    idle_inputs();
    check("hlt_wb_hlt", wb_hlt, 1);
    check("hlt_wb_vld", wb_vld, 1);
    check("hlt_wb_we",  wb_we,  0);
    check("hlt_stall",  stall,  1);
    check("hlt_dm_req", dm_req, 0);
    for (int c = 0; c < 4; c++) begin
      ex_vld = 1; ex_mem_re = (c % 2 == 0); ex_dst = 16'h0300; ex_rf_we = 1;
      dm_rdy = 1;
      tick();
      check($sformatf("hlt%0d_dm_req", c), dm_req, 0);
      check($sformatf("hlt%0d_wb_vld", c), wb_vld, 0);
      check($sformatf("hlt%0d_stall", c),  stall,  1);
      check($sformatf("hlt%0d_wb_hlt", c), wb_hlt, 1);
    end
    idle_inputs();
    dm_rdy = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
